// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: boot sequencer for the single-cycle core.
// The block owns the instruction and data BRAM write ports while a program
// and data image arrive over a valid/ready stream. It then releases the core
// to run for a programmed number of cycles, or until halt_req is seen.
// Ports:
//   clk, rst (async, active-low)
//   start, d_words, i_words, run_cycles, halt_req : sequence control
//   ld_valid, ld_data, ld_ready                    : load stream
//   d_w_addr/d_w_dat/d_w_enb, i_w_addr/i_w_dat/i_w_enb : BRAM write ports
//   d_bram_init_done, pc_stall, i_r_enb, rd_enbl   : core run controls
//   busy, done, err                                : status
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            d_words,
  input  logic [8:0]            i_words,
  input  logic [15:0]           run_cycles,
  input  logic                  halt_req,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_I = 3'd2,
    FLUSH  = 3'd3,
    RUN    = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t                state_r, nxt_state_s;
  logic                  err_r, nxt_err_s;
  logic [8:0]            rem_r, nxt_rem_s;          // words still to load in current phase
  logic [8:0]            i_words_r, nxt_i_words_s;
  logic [15:0]           run_len_r, nxt_run_len_s;
  logic [15:0]           run_cnt_r, nxt_run_cnt_s;
  logic [7:0]            idx_r, nxt_idx_s;          // word index within current BRAM
  logic                  hs_s;
  logic                  ld_ready_s;
  logic [ADDR_WIDTH-1:0] word_addr_s;

  logic                  d_w_enb_r, i_w_enb_r;
  logic [ADDR_WIDTH-1:0] d_w_addr_r, i_w_addr_r;
  logic [DATA_WIDTH-1:0] d_w_dat_r, i_w_dat_r;
  logic                  pc_stall_r, i_r_enb_r, rd_enbl_r, init_done_r, busy_r, done_r;
  logic                  nxt_pc_stall_s, nxt_i_r_enb_s, nxt_rd_enbl_s;
  logic                  nxt_init_done_s, nxt_busy_s, nxt_done_s;

  assign ld_ready_s  = (state_r == LOAD_D) || (state_r == LOAD_I);
  assign hs_s        = ld_valid && ld_ready_s;
  assign word_addr_s = ADDR_WIDTH'({idx_r, 2'b00});

  // Next-state and bookkeeping; load phases terminate on the word count, not the index.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_err_s     = err_r;
    nxt_rem_s     = rem_r;
    nxt_i_words_s = i_words_r;
    nxt_run_len_s = run_len_r;
    nxt_run_cnt_s = run_cnt_r;
    nxt_idx_s     = idx_r;
    case (state_r)
      IDLE, HALT: begin
        if (start) begin
          if ((d_words > 9'd256) || (i_words > 9'd256)) begin
            nxt_err_s = 1'b1;
          end else begin
            nxt_err_s     = 1'b0;
            nxt_i_words_s = i_words;
            nxt_run_len_s = run_cycles;
            nxt_run_cnt_s = 16'd0;
            nxt_idx_s     = 8'd0;
            if (d_words != 9'd0) begin
              nxt_state_s = LOAD_D;
              nxt_rem_s   = d_words;
            end else if (i_words != 9'd0) begin
              nxt_state_s = LOAD_I;
              nxt_rem_s   = i_words;
            end else begin
              nxt_state_s = FLUSH;
              nxt_rem_s   = 9'd0;
            end
          end
        end else begin
          nxt_state_s = state_r;
        end
      end
      LOAD_D: begin
        if (hs_s) begin
          if (rem_r == 9'd1) begin
            nxt_idx_s = 8'd0;
            if (i_words_r != 9'd0) begin
              nxt_state_s = LOAD_I;
              nxt_rem_s   = i_words_r;
            end else begin
              nxt_state_s = FLUSH;
              nxt_rem_s   = 9'd0;
            end
          end else begin
            nxt_idx_s = idx_r + 8'd1;
            nxt_rem_s = rem_r - 9'd1;
          end
        end else begin
          nxt_state_s = state_r;
        end
      end
      LOAD_I: begin
        if (hs_s) begin
          if (rem_r == 9'd1) begin
            nxt_idx_s   = 8'd0;
            nxt_state_s = FLUSH;
            nxt_rem_s   = 9'd0;
          end else begin
            nxt_idx_s = idx_r + 8'd1;
            nxt_rem_s = rem_r - 9'd1;
          end
        end else begin
          nxt_state_s = state_r;
        end
      end
      FLUSH: begin
        nxt_state_s   = RUN;
        nxt_run_cnt_s = 16'd0;
      end
      RUN: begin
        // A zero budget never matches, so the core runs until halt_req.
        if (halt_req) begin
          nxt_state_s = HALT;
        end else if ((run_len_r != 16'd0) && (run_cnt_r == (run_len_r - 16'd1))) begin
          nxt_state_s = HALT;
        end else begin
          nxt_run_cnt_s = run_cnt_r + 16'd1;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // Run-control decode of the next state, so the registered outputs track the state register.
  always_comb begin
    nxt_pc_stall_s  = 1'b1;
    nxt_i_r_enb_s   = 1'b0;
    nxt_rd_enbl_s   = 1'b0;
    nxt_init_done_s = 1'b0;
    nxt_busy_s      = 1'b0;
    nxt_done_s      = 1'b0;
    case (nxt_state_s)
      LOAD_D, LOAD_I, FLUSH: begin
        nxt_busy_s = 1'b1;
      end
      RUN: begin
        nxt_pc_stall_s  = 1'b0;
        nxt_i_r_enb_s   = 1'b1;
        nxt_rd_enbl_s   = 1'b1;
        nxt_init_done_s = 1'b1;
        nxt_busy_s      = 1'b1;
      end
      HALT: begin
        nxt_rd_enbl_s   = 1'b1;
        nxt_init_done_s = 1'b1;
        nxt_done_s      = 1'b1;
      end
      default: begin
        nxt_busy_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Bookkeeping, BRAM write ports and run-control output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r       <= 1'b0;
      rem_r       <= 9'd0;
      i_words_r   <= 9'd0;
      run_len_r   <= 16'd0;
      run_cnt_r   <= 16'd0;
      idx_r       <= 8'd0;
      d_w_enb_r   <= 1'b0;
      d_w_addr_r  <= '0;
      d_w_dat_r   <= '0;
      i_w_enb_r   <= 1'b0;
      i_w_addr_r  <= '0;
      i_w_dat_r   <= '0;
      pc_stall_r  <= 1'b1;
      i_r_enb_r   <= 1'b0;
      rd_enbl_r   <= 1'b0;
      init_done_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      err_r       <= nxt_err_s;
      rem_r       <= nxt_rem_s;
      i_words_r   <= nxt_i_words_s;
      run_len_r   <= nxt_run_len_s;
      run_cnt_r   <= nxt_run_cnt_s;
      idx_r       <= nxt_idx_s;
      d_w_enb_r   <= hs_s && (state_r == LOAD_D);
      i_w_enb_r   <= hs_s && (state_r == LOAD_I);
      if (hs_s && (state_r == LOAD_D)) begin
        d_w_addr_r <= word_addr_s;
        d_w_dat_r  <= ld_data;
      end
      if (hs_s && (state_r == LOAD_I)) begin
        i_w_addr_r <= word_addr_s;
        i_w_dat_r  <= ld_data;
      end
      pc_stall_r  <= nxt_pc_stall_s;
      i_r_enb_r   <= nxt_i_r_enb_s;
      rd_enbl_r   <= nxt_rd_enbl_s;
      init_done_r <= nxt_init_done_s;
      busy_r      <= nxt_busy_s;
      done_r      <= nxt_done_s;
    end
  end

  assign ld_ready         = ld_ready_s;
  assign d_w_addr         = d_w_addr_r;
  assign d_w_dat          = d_w_dat_r;
  assign d_w_enb          = d_w_enb_r;
  assign i_w_addr         = i_w_addr_r;
  assign i_w_dat          = i_w_dat_r;
  assign i_w_enb          = i_w_enb_r;
  assign d_bram_init_done = init_done_r;
  assign pc_stall         = pc_stall_r;
  assign i_r_enb          = i_r_enb_r;
  assign rd_enbl          = rd_enbl_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;

endmodule
